// File: rtl/cla_adder_pkg.sv
// Shared constants and helpers for the carry-look-ahead adder.
package cla_adder_pkg;

    // Bits per look-ahead group; wider adders are cascades of these.
    localparam int CLA_GROUP = 4;

    // Number of 4-bit groups needed for an operand width.
    function automatic int num_groups(input int width);
        return width / CLA_GROUP;
    endfunction

endpackage

// File: rtl/cla_adder_group4.sv
// One 4-bit carry-look-ahead group: flattened carry equations, no internal ripple.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4,
    output logic       pg,
    output logic       gg
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;

    // Bit generate/propagate, flattened carries, sum bits and group terms.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        s  = p ^ {c3, c2, c1, c0};
        pg = &p;
        // Group generate is c4 with the carry-in forced to zero.
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/cla_adder.sv
// Registered carry-look-ahead adder built from cascaded 4-bit groups.
// WIDTH must be a positive multiple of 4. One-cycle latency, no backpressure:
// a result is captured on every rising edge where in_valid is high, and
// out_valid mirrors in_valid one cycle later. Results hold while idle.
module cla_adder
    import cla_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             grp_p,
    output logic             grp_g
);

    localparam int NG = num_groups(WIDTH);

    logic [WIDTH-1:0] sum_c;
    logic [NG-1:0]    pg;
    logic [NG-1:0]    gg;
    logic             cout_c;
    logic             grp_p_c;
    logic             grp_g_c;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : grp
            logic c_in;
            logic c4_w;

            // A group's c4 already equals GG | PG & c_in, so the next group
            // takes it directly as its carry-in (groups ripple).
            if (gi == 0) begin : g_first
                assign c_in = cin;
            end else begin : g_next
                assign c_in = grp[gi-1].c4_w;
            end

            cla_group4 u_group (
                .a  (a[gi*CLA_GROUP +: CLA_GROUP]),
                .b  (b[gi*CLA_GROUP +: CLA_GROUP]),
                .c0 (c_in),
                .s  (sum_c[gi*CLA_GROUP +: CLA_GROUP]),
                .c4 (c4_w),
                .pg (pg[gi]),
                .gg (gg[gi])
            );
        end
    endgenerate

    assign cout_c = grp[NG-1].c4_w;

    // Whole-word propagate, and whole-word generate (carry chain with cin = 0).
    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < NG; i++) begin
            acc = gg[i] | (pg[i] & acc);
        end
        grp_g_c = acc;
        grp_p_c = &pg;
    end

    // Result registers load only on valid input; idle inputs never reach them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            cout  <= 1'b0;
            grp_p <= 1'b0;
            grp_g <= 1'b0;
        end else if (in_valid) begin
            sum   <= sum_c;
            cout  <= cout_c;
            grp_p <= grp_p_c;
            grp_g <= grp_g_c;
        end
    end

    // out_valid tracks in_valid with one cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder: directed table, reset corner cases,
// exhaustive 4-bit sweep and randomized 16-bit traffic against an
// arithmetic reference model.
module tb_cla_adder;

    // Expected word layout: {out_valid, grp_g, grp_p, cout, sum[15:0]}
    localparam int EW = 20;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       valid;
        logic [3:0] e_sum;
        logic       e_cout;
        logic       e_gp;
        logic       e_gg;
        logic       e_ov;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT WIDTH=4 ----------------
    logic        iv4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        cin4 = 1'b0;
    logic        ov4, cout4, gp4, gg4;
    logic [3:0]  sum4;

    cla_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .sum(sum4), .cout(cout4), .grp_p(gp4), .grp_g(gg4)
    );

    // ---------------- DUT WIDTH=16 ----------------
    logic        iv16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        cin16 = 1'b0;
    logic        ov16, cout16, gp16, gg16;
    logic [15:0] sum16;

    cla_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .a(a16), .b(b16), .cin(cin16),
        .out_valid(ov16), .sum(sum16), .cout(cout16), .grp_p(gp16), .grp_g(gg16)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q4[$];
    logic [EW-1:0] exp_q16[$];
    logic [EW-2:0] last4 = '0;   // held result fields, model side
    logic [EW-2:0] last16 = '0;
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [EW-1:0] act4();
        return {ov4, gg4, gp4, cout4, 12'h000, sum4};
    endfunction

    function automatic logic [EW-1:0] act16();
        return {ov16, gg16, gp16, cout16, sum16};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got ov=%0b gg=%0b gp=%0b cout=%0b sum=%h, required ov=%0b gg=%0b gp=%0b cout=%0b sum=%h",
                     name, act[19], act[18], act[17], act[16], act[15:0],
                     exp[19], exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    // Reference model: plain unsigned arithmetic.
    function automatic logic [EW-2:0] model(input logic [15:0] va, input logic [15:0] vb,
                                            input logic vc, input int w);
        logic [16:0] full;
        logic [16:0] nocin;
        logic [15:0] mask;
        logic        gp;
        logic        gg;
        logic        co;
        mask  = (w == 16) ? 16'hFFFF : 16'h000F;
        full  = {1'b0, va & mask} + {1'b0, vb & mask} + {16'h0000, vc};
        nocin = {1'b0, va & mask} + {1'b0, vb & mask};
        co    = (w == 16) ? full[16] : full[4];
        gg    = (w == 16) ? nocin[16] : nocin[4];
        gp    = (((va ^ vb) & mask) == mask);
        return {gg, gp, co, full[15:0] & mask};
    endfunction

    // Advance to the next falling edge and check whatever result is due.
    task automatic tick();
        @(negedge clk);
        if (exp_q4.size() > 0) check("w4", act4(), exp_q4.pop_front());
        if (exp_q16.size() > 0) check("w16", act16(), exp_q16.pop_front());
    endtask

    task automatic drive4_exp(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                              input logic vv, input logic [EW-2:0] res);
        a4 = va; b4 = vb; cin4 = vc; iv4 = vv;
        if (vv) last4 = res;
        exp_q4.push_back({vv, last4});
    endtask

    task automatic drive4(input logic [3:0] va, input logic [3:0] vb, input logic vc, input logic vv);
        drive4_exp(va, vb, vc, vv, model({12'h000, va}, {12'h000, vb}, vc, 4));
    endtask

    task automatic drive16(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vv);
        a16 = va; b16 = vb; cin16 = vc; iv16 = vv;
        if (vv) last16 = model(va, vb, vc, 16);
        exp_q16.push_back({vv, last16});
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[8];

    initial begin
        tbl[0] = '{4'd5,  4'd6,  1'b1, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{4'd15, 4'd0,  1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{4'd15, 4'd15, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{4'd0,  4'd0,  1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{4'd3,  4'd4,  1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{4'd9,  4'd9,  1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{4'd10, 4'd5,  1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{4'd10, 4'd5,  1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state with rst held across edges.
        repeat (2) @(negedge clk);
        check("reset_w4", act4(), '0);
        check("reset_w16", act16(), '0);
        rst = 1'b0;

        // Directed table, back-to-back, expectations written out by hand.
        for (int i = 0; i < 8; i++) begin
            tick();
            drive4_exp(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].valid,
                       {tbl[i].e_gg, tbl[i].e_gp, tbl[i].e_cout, 12'h000, tbl[i].e_sum});
            if (!tbl[i].valid) begin
                // Held fields must come from the table, not from the model.
                exp_q4[exp_q4.size()-1] = {tbl[i].e_ov, tbl[i].e_gg, tbl[i].e_gp,
                                           tbl[i].e_cout, 12'h000, tbl[i].e_sum};
            end
        end
        tick();
        drive4(4'd0, 4'd0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset mid-operation: no clock edge needed.
        drive4(4'd5, 4'd6, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        exp_q4.delete();
        rst = 1'b1;
        #1;
        check("async_rst", act4(), '0);
        // Operation still presented while rst held is discarded.
        @(posedge clk);
        #1;
        check("rst_held", act4(), '0);
        last4 = '0;
        @(negedge clk);
        rst = 1'b0;
        drive4(4'd3, 4'd4, 1'b0, 1'b1);
        tick();
        drive4(4'd9, 4'd9, 1'b1, 1'b0);
        tick();
        drive4(4'd1, 4'd2, 1'b0, 1'b0);

        // Exhaustive 4-bit sweep, back-to-back.
        for (int x = 0; x < 512; x++) begin
            logic [8:0] v;
            v = x[8:0];
            tick();
            drive4(v[8:5], v[4:1], v[0], 1'b1);
        end
        tick();
        drive4(4'hF, 4'hF, 1'b1, 1'b0);
        tick();

        // Randomized 16-bit traffic with occasional idle cycles carrying junk.
        for (int n = 0; n < 10000; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = ~ra;            // full propagate
                1: rb = 16'hFFFF - ra + 16'd1;
                default: ;
            endcase
            tick();
            drive16(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
        end
        tick();
        drive16(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
